// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game logic and the renderer that
// reads the packed segment positions.
package snake_pkg;

   // Movement direction of the head
   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   // Game state as seen on the state output
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DEAD  = 2'd3
   } state_t;

   // PS/2 set-2 make codes the game reacts to
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_ENTER = 8'h5A;

   // Field ranges of one 13-bit segment word {y, x}
   localparam int POS_X_LSB = 0;
   localparam int POS_X_MSB = 6;
   localparam int POS_Y_LSB = 7;
   localparam int POS_Y_MSB = 12;
   localparam int POS_W     = 13;

   typedef struct packed {
      logic [5:0] y;
      logic [6:0] x;
   } pos_t;

   // Direction that would make the head turn back into its own neck
   function automatic dir_t opposite(input dir_t d);
      dir_t r;
      case (d)
         UP:      r = DOWN;
         DOWN:    r = UP;
         LEFT:    r = RIGHT;
         default: r = LEFT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/snake_if.sv
// Key/tick inputs and position/state outputs of the snake game logic.
// The master side is whoever feeds keys and frame ticks; the game logic is
// the slave.
interface snake_if #(
   parameter int SEGMENTS = 4
);
   logic                     move_tick;
   logic                     key_valid;
   logic [7:0]               key_code;
   logic [SEGMENTS*13-1:0]   positions;
   logic [1:0]               state;
   logic                     died;

   modport master (
      output move_tick, key_valid, key_code,
      input  positions, state, died
   );

   modport slave (
      input  move_tick, key_valid, key_code,
      output positions, state, died
   );
endinterface

// File: rtl/snake_next_head.sv
// Combinational next-head calculation. The wall test is done on the current
// coordinate before any increment or decrement, so a move off the grid is
// flagged instead of producing a wrapped coordinate.
module snake_next_head
   import snake_pkg::*;
#(
   parameter int GRID_W = 64,
   parameter int GRID_H = 48
) (
   input  pos_t head,
   input  dir_t dir,
   output pos_t next_head,
   output logic wall_hit
);

   // Step the head one cell in dir unless it already sits on that wall
   always_comb begin
      next_head = head;
      wall_hit  = 1'b0;
      case (dir)
         UP: begin
            if (head.y == 6'd0) wall_hit = 1'b1;
            else                next_head.y = head.y - 6'd1;
         end
         DOWN: begin
            if (head.y == 6'(GRID_H - 1)) wall_hit = 1'b1;
            else                          next_head.y = head.y + 6'd1;
         end
         LEFT: begin
            if (head.x == 7'd0) wall_hit = 1'b1;
            else                next_head.x = head.x - 7'd1;
         end
         default: begin
            if (head.x == 7'(GRID_W - 1)) wall_hit = 1'b1;
            else                          next_head.x = head.x + 7'd1;
         end
      endcase
   end

endmodule

// File: rtl/snake_motion.sv
// Snake game logic: turns key events and per-frame ticks into segment
// positions and a game state for the VGA renderer.
module snake_motion
   import snake_pkg::*;
#(
   parameter int SEGMENTS = 4,
   parameter int GRID_W   = 64,
   parameter int GRID_H   = 48,
   parameter int INIT_Y   = 24
) (
   input logic     clk,
   input logic     rst_n,
   snake_if.slave  bus
);

   state_t state_q, state_d;
   dir_t   dir_q, dir_d;
   dir_t   pend_q, pend_d;
   pos_t   seg_q [SEGMENTS];
   pos_t   seg_d [SEGMENTS];
   logic   died_q, died_d;

   pos_t   next_head;
   logic   wall_hit;
   logic   self_hit;

   logic   is_dir_key;
   dir_t   key_dir;
   logic   is_space;
   logic   is_enter;

   // Starting layout: a horizontal snake on INIT_Y with its head furthest right
   function automatic pos_t init_pos(input int i);
      pos_t p;
      p.y = 6'(INIT_Y);
      p.x = 7'(SEGMENTS - 1 - i);
      return p;
   endfunction

   // The move always uses the direction queued before this edge
   snake_next_head #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_next_head (
      .head      (seg_q[0]),
      .dir       (pend_q),
      .next_head (next_head),
      .wall_hit  (wall_hit)
   );

   // Decode the incoming make code into a direction or a command
   always_comb begin
      is_dir_key = 1'b0;
      key_dir    = RIGHT;
      is_space   = bus.key_valid && (bus.key_code == KEY_SPACE);
      is_enter   = bus.key_valid && (bus.key_code == KEY_ENTER);
      if (bus.key_valid) begin
         case (bus.key_code)
            KEY_UP:    begin is_dir_key = 1'b1; key_dir = UP;    end
            KEY_DOWN:  begin is_dir_key = 1'b1; key_dir = DOWN;  end
            KEY_LEFT:  begin is_dir_key = 1'b1; key_dir = LEFT;  end
            KEY_RIGHT: begin is_dir_key = 1'b1; key_dir = RIGHT; end
            default:   ;
         endcase
      end
   end

   // The tail is left out of the collision test because it moves away this cycle
   always_comb begin
      self_hit = 1'b0;
      for (int i = 0; i < SEGMENTS - 1; i++) begin
         if (seg_q[i] == next_head) self_hit = 1'b1;
      end
   end

   // Game state machine, direction queue and segment shifting
   always_comb begin
      logic do_restart;
      dir_t ref_dir;

      state_d    = state_q;
      dir_d      = dir_q;
      pend_d     = pend_q;
      died_d     = 1'b0;
      do_restart = 1'b0;
      ref_dir    = dir_q;
      for (int i = 0; i < SEGMENTS; i++) seg_d[i] = seg_q[i];

      case (state_q)
         IDLE: begin
            if (is_dir_key && (key_dir != opposite(dir_q))) begin
               pend_d  = key_dir;
               state_d = RUN;
            end
         end

         RUN: begin
            if (is_enter) begin
               do_restart = 1'b1;
            end else if (is_space) begin
               state_d = PAUSE;
            end else begin
               if (bus.move_tick) begin
                  dir_d   = pend_q;
                  ref_dir = pend_q;
                  if (wall_hit || self_hit) begin
                     state_d = DEAD;
                     died_d  = 1'b1;
                  end else begin
                     for (int i = 1; i < SEGMENTS; i++) seg_d[i] = seg_q[i-1];
                     seg_d[0] = next_head;
                  end
               end
               // A key arriving with a tick is judged against the direction
               // the snake has just taken
               if (is_dir_key && (key_dir != opposite(ref_dir))) pend_d = key_dir;
            end
         end

         PAUSE: begin
            if (is_enter) begin
               do_restart = 1'b1;
            end else if (is_space) begin
               state_d = RUN;
            end else if (is_dir_key && (key_dir != opposite(dir_q))) begin
               pend_d = key_dir;
            end
         end

         default: begin
            if (is_enter) do_restart = 1'b1;
         end
      endcase

      if (do_restart) begin
         state_d = IDLE;
         dir_d   = RIGHT;
         pend_d  = RIGHT;
         for (int i = 0; i < SEGMENTS; i++) seg_d[i] = init_pos(i);
      end
   end

   // State and position registers, cleared to the starting layout on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dir_q   <= RIGHT;
         pend_q  <= RIGHT;
         died_q  <= 1'b0;
         for (int i = 0; i < SEGMENTS; i++) seg_q[i] <= init_pos(i);
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         pend_q  <= pend_d;
         died_q  <= died_d;
         for (int i = 0; i < SEGMENTS; i++) seg_q[i] <= seg_d[i];
      end
   end

   genvar g;
   generate
      for (g = 0; g < SEGMENTS; g++) begin : g_pack
         assign bus.positions[POS_W*g +: POS_W] = seg_q[g];
      end
   endgenerate

   assign bus.state = state_q;
   assign bus.died  = died_q;

endmodule
